// File: rtl/fir_err_monitor.sv
// Error-metrics observer: compares approximate vs exact FIR output over a 2^WIN_LOG2 window
// after discarding SETTLE samples; reports sum/max/count of |error| with a start/done handshake.
module fir_err_monitor #(
  parameter int WIN_LOG2 = 8,
  parameter int SETTLE   = 9,
  parameter int CNT_W    = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [15:0]      y_apx,
  input  logic signed [15:0]      y_ref,
  output logic                    busy,
  output logic                    done,
  output logic                    res_valid,
  output logic [16+WIN_LOG2-1:0]  sum_abs_err,
  output logic [15:0]             max_abs_err,
  output logic [WIN_LOG2:0]       err_count,
  output logic [15:0]             mean_abs_err
);

  localparam int SUM_W = 16 + WIN_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(1) << WIN_LOG2;

  typedef enum logic [2:0] {IDLE, SKIP, ACCUM, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             busy_q, done_q, rv_q;
  logic             accept, acc_clr;

  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = (state_q == ACCUM) && in_valid;
  assign acc_clr = (state_q == IDLE) && start;

  // cnt_q counts settle samples, then window samples, then the two drain cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (SETTLE == 0) ? ACCUM : SKIP;
          end
        end
        SKIP: begin
          if (in_valid) begin
            if (cnt_inc == SETTLE_C) begin
              cnt_q   <= '0;
              state_q <= ACCUM;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (cnt_inc == WIN_C) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rv_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic signed [16:0] diff_d, diff_q;
  logic [15:0]        abs_d, abs_q;
  logic               s1_vld_q, s2_vld_q, nz_q;
  logic [SUM_W-1:0]   sum_q;
  logic [15:0]        max_q;
  logic [WIN_LOG2:0]  ecnt_q;

  assign diff_d = {y_apx[15], y_apx} - {y_ref[15], y_ref};
  // |diff| peaks at 65535, so the 16-bit truncation of the negation is exact.
  assign abs_d  = diff_q[16] ? 16'(-diff_q) : diff_q[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      diff_q   <= '0;
      abs_q    <= '0;
      nz_q     <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (accept) diff_q <= diff_d;
      if (s1_vld_q) begin
        abs_q <= abs_d;
        nz_q  <= |diff_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      max_q  <= '0;
      ecnt_q <= '0;
    end else if (acc_clr) begin
      sum_q  <= '0;
      max_q  <= '0;
      ecnt_q <= '0;
    end else if (s2_vld_q) begin
      sum_q  <= sum_q + {{WIN_LOG2{1'b0}}, abs_q};
      ecnt_q <= ecnt_q + {{WIN_LOG2{1'b0}}, nz_q};
      if (abs_q > max_q) max_q <= abs_q;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign res_valid    = rv_q;
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;
  assign err_count    = ecnt_q;
  assign mean_abs_err = sum_q[WIN_LOG2 +: 16];

endmodule

// File: tb/tb_fir_err_monitor.sv
// Randomized bench for fir_err_monitor with a window-level reference model and per-cycle checker.
module tb_fir_err_monitor;
  localparam int W   = 2;
  localparam int S   = 1;
  localparam int N   = 1 << W;
  localparam int BIG = 100000000;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic signed [15:0] y_apx, y_ref;
  logic busy, done, res_valid;
  logic [16+W-1:0] sum_abs_err;
  logic [15:0] max_abs_err, mean_abs_err;
  logic [W:0] err_count;

  fir_err_monitor #(.WIN_LOG2(W), .SETTLE(S), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .y_apx(y_apx), .y_ref(y_ref), .busy(busy), .done(done),
    .res_valid(res_valid), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .err_count(err_count),
    .mean_abs_err(mean_abs_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int run_start = -1;
  int run_last = BIG;
  int prev_rv = 0, prev_sum = 0, prev_max = 0, prev_cnt = 0;
  int m_sum = 0, m_max = 0, m_cnt = 0;
  int sa[$];
  int sr[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int a, input int r);
    sa.push_back(a);
    sr.push_back(r);
  endtask

  // Per-cycle checker: expected outputs follow from when the run started and
  // when its last window sample was accepted.
  initial begin
    int exp_rv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (run_start < 0 || cyc <= run_start) begin
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("res_valid_idle", res_valid, prev_rv);
        chk("sum_idle", sum_abs_err, prev_sum);
        chk("max_idle", max_abs_err, prev_max);
        chk("cnt_idle", err_count, prev_cnt);
        chk("mean_idle", mean_abs_err, prev_sum >> W);
      end else begin
        chk("busy", busy, cyc <= run_last + 2);
        chk("done", done, cyc == run_last + 3);
        exp_rv = (cyc >= run_last + 3) ? 1 : 0;
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv != 0) begin
          chk("sum", sum_abs_err, m_sum);
          chk("max", max_abs_err, m_max);
          chk("cnt", err_count, m_cnt);
          chk("mean", mean_abs_err, m_sum >> W);
        end
      end
    end
  end

  task automatic model_reset();
    run_start = -1;
    run_last  = BIG;
    prev_rv = 0; prev_sum = 0; prev_max = 0; prev_cnt = 0;
    m_sum = 0; m_max = 0; m_cnt = 0;
  endtask

  task automatic run(input bit gaps, input bit stray, input int abort_at);
    int nv;
    int d;
    int g;
    @(posedge clk); #1;
    if (run_start >= 0) begin
      prev_rv = 1; prev_sum = m_sum; prev_max = m_max; prev_cnt = m_cnt;
    end
    m_sum = 0; m_max = 0; m_cnt = 0;
    run_start = cyc;
    run_last  = BIG;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nv = 0;
    foreach (sa[i]) begin
      if (gaps) begin
        g = $urandom_range(1, 2);
        repeat (g) begin
          in_valid = 1'b0;
          y_apx = 16'($urandom);
          y_ref = 16'($urandom);
          if (stray && nv < S + N) start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      in_valid = 1'b1;
      y_apx = 16'(sa[i]);
      y_ref = 16'(sr[i]);
      nv++;
      if (nv > S && nv <= S + N) begin
        d = sa[i] - sr[i];
        if (d < 0) d = -d;
        m_sum += d;
        if (d > m_max) m_max = d;
        if (d != 0) m_cnt++;
        if (nv == S + N) run_last = cyc;
      end
      @(posedge clk); #1;
      if (nv == abort_at) begin
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_res_valid", res_valid, 0);
        chk("async_sum", sum_abs_err, 0);
        chk("async_max", max_abs_err, 0);
        chk("async_cnt", err_count, 0);
        chk("async_mean", mean_abs_err, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        sa.delete();
        sr.delete();
        return;
      end
    end
    in_valid = 1'b0;
    if (run_last != BIG) begin
      while (cyc < run_last + 3) begin
        @(posedge clk); #1;
      end
      if (stray && cyc == run_last + 3) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sa.delete();
    sr.delete();
  endtask

  task automatic lit(input string nm, input int s, input int mx, input int c, input int mn);
    chk({nm, "_res_valid"}, res_valid, 1);
    chk({nm, "_sum"}, sum_abs_err, s);
    chk({nm, "_max"}, max_abs_err, mx);
    chk({nm, "_cnt"}, err_count, c);
    chk({nm, "_mean"}, mean_abs_err, mn);
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  initial begin
    int base, ns;
    bit gp, st;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; y_apx = '0; y_ref = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    repeat (5) push(100, 100);
    run(1'b0, 1'b0, 0);
    lit("exact", 0, 0, 0, 0);

    push(7, 0); push(13, 10); push(-5, 0); push(4, 4); push(-1, -3);
    run(1'b0, 1'b0, 0);
    lit("known", 10, 5, 3, 2);

    repeat (5) push(32767, -32768);
    run(1'b0, 1'b0, 0);
    lit("extreme", 262140, 65535, 4, 65535);

    push(7, 0); push(13, 10); push(-5, 0); push(4, 4); push(-1, -3);
    run(1'b1, 1'b1, 0);
    lit("gaps", 10, 5, 3, 2);

    push(1, 0); push(20, 3); push(-9, 9); push(5, 5); push(6, 6);
    run(1'b0, 1'b0, S + 2);
    repeat (5) push(-7, -7);
    run(1'b0, 1'b0, 0);
    lit("fresh", 0, 0, 0, 0);

    for (int r = 0; r < 24; r++) begin
      ns = S + N + $urandom_range(0, 2);
      for (int k = 0; k < ns; k++) begin
        base = $urandom_range(0, 65535) - 32768;
        if (r % 2 == 0) push(base, clamp16(base + $urandom_range(0, 6) - 3));
        else push(base, $urandom_range(0, 65535) - 32768);
      end
      gp = 1'($urandom_range(0, 1));
      st = (ns == S + N) && ($urandom_range(0, 1) == 1);
      run(gp, st, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_err_monitor.md
Name: fir_err_monitor

Overview:
Downstream observer for the approximate-adder FIR datapath. It compares the approximate filter output against an exact-arithmetic filter output, sample by sample, over a programmable window. It accumulates sum of absolute error, maximum absolute error and mismatch count, and reports the results with a start/done handshake. It sits after the filter output register and feeds the error-metrics readout used for characterising approximate adders.

Parameters:
WIN_LOG2, 8, log2 of the measurement window length in samples (window N = 2^WIN_LOG2); legal range 1..16
SETTLE, 9, number of valid samples discarded after start, to flush the filter delay line; 0 allowed
CNT_W, 17, counter width; must satisfy 2^CNT_W > max(N, SETTLE)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a measurement; honoured only in IDLE
in_valid  input  1  y_apx/y_ref pair valid this cycle
y_apx  input  16  approximate filter output, signed
y_ref  input  16  exact filter output, signed
busy  output  1  high in SKIP, ACCUM and DRAIN
done  output  1  one-cycle pulse when results are final
res_valid  output  1  results hold a completed measurement; cleared on accepted start
sum_abs_err  output  16+WIN_LOG2  sum of |y_apx - y_ref| over the window, unsigned
max_abs_err  output  16  maximum |y_apx - y_ref| over the window, unsigned
err_count  output  WIN_LOG2+1  number of window samples with nonzero error
mean_abs_err  output  16  sum_abs_err >> WIN_LOG2 (truncating)

Behaviour:
- Reset (async, any state): state=IDLE; all counters, pipeline registers and result registers = 0; busy=done=res_valid=0.
- FSM states: IDLE, SKIP, ACCUM, DRAIN, DONE.
  - IDLE: on start=1, clear all results, clear res_valid and the sample counter. Go to SKIP, or to ACCUM if SETTLE=0.
  - SKIP: each in_valid increments the counter. When SETTLE samples have been consumed, clear the counter and go to ACCUM.
  - ACCUM: each in_valid sample enters the pipeline and increments the counter. When the Nth sample is accepted, go to DRAIN; later samples are ignored.
  - DRAIN: exactly 2 cycles, letting the pipeline empty, then DONE.
  - DONE: one cycle; done=1, res_valid set; next state IDLE.
- in_valid=0 cycles stall counting in every state; gaps of any length are legal. in_valid is ignored in IDLE, DRAIN and DONE.
- start outside IDLE is ignored, including in the DONE cycle. Results stay stable from DONE until the next accepted start.
- Datapath pipeline, 3 stages:
  - Stage 1: diff = sign-extended 17-bit (y_apx - y_ref), registered with a valid bit.
  - Stage 2: abs(diff), 16-bit unsigned (range 0..65535, no overflow); nz = (diff != 0); registered.
  - Stage 3: sum_abs_err += abs; max_abs_err = max(max_abs_err, abs); err_count += nz.
  - A sample accepted at cycle t is reflected in the results at the end of cycle t+2. Accumulators never wrap, because widths cover the worst case (N × 65535).
- mean_abs_err is combinational from sum_abs_err.
- Reset mid-operation aborts the measurement; there are no partial results and res_valid=0.

Test Plan:
(All with WIN_LOG2=2, SETTLE=1.)
1. Reset: assert rst mid-stream → all outputs 0 immediately (asynchronous), state IDLE, busy=0.
2. Exact match: start, then 5 valid samples with y_apx=y_ref=100 → done after the 5th sample + 3 cycles; sum=0, max=0, err_count=0, mean=0, res_valid=1.
3. Known errors:
   - Stimulus: start; skip sample (7,0); then diffs +3, −5, 0, +2 (e.g. apx/ref = 13/10, −5/0, 4/4, −1/−3).
   - Required: sum=10, max=5, err_count=3, mean=2; the skipped sample does not contribute.
4. Extremes: y_apx=32767, y_ref=−32768 for all 4 window samples → sum=262140, max=65535, err_count=4, mean=65535.
5. Gaps and stray starts:
   - Stimulus: in_valid toggled 1/0 through the window; start pulsed during ACCUM and in the DONE cycle.
   - Required: results identical to the gap-free run; extra starts ignored; one done pulse only.
6. Reset mid-ACCUM:
   - Stimulus: after 2 window samples, pulse rst; then start a fresh run with zero error.
   - Required: no done from the aborted run; fresh run reports sum=0, err_count=0.
